// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan controller.
//   state_t : FSM encoding (ST_IDLE = 0, ST_SCAN = 1)
//   CH_NUM  : number of mux channels scanned
//   SEL_W   : width of the mux select bus
package mux_scan_pkg;

    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/mux_scan_ctrl_chan_next_sel.sv
// Combinational channel picker for the mux scan controller.
//   en      [3:0] : channel enable mask
//   cur_sel [1:0] : currently selected channel
//   first         : 1 = return the lowest enabled channel,
//                   0 = return the next enabled channel above cur_sel
//   nxt_sel [1:0] : chosen channel (holds cur_sel / 0 when none qualifies)
//   last          : no enabled channel exists above the reference channel
//                   (the chosen one when first=1, cur_sel when first=0)
module chan_next_sel
    import mux_scan_pkg::*;
(
    input  logic [CH_NUM-1:0] en,
    input  logic [SEL_W-1:0]  cur_sel,
    input  logic              first,
    output logic [SEL_W-1:0]  nxt_sel,
    output logic              last
);

    logic found;
    logic above;
    int   ref_ch;

    always_comb begin
        nxt_sel = first ? '0 : cur_sel;
        found   = 1'b0;
        // Ascending scan, first hit wins: lowest qualifying channel.
        for (int i = 0; i < CH_NUM; i++) begin
            if (en[i] && !found && (first || (i > int'(cur_sel)))) begin
                nxt_sel = SEL_W'(i);
                found   = 1'b1;
            end
        end

        ref_ch = first ? int'(nxt_sel) : int'(cur_sel);
        above  = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (en[i] && (i > ref_ch)) begin
                above = 1'b1;
            end
        end
        last = !above;
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan controller placed in front of a 4:1 channel mux.
// Holds each enabled channel's select for DWELL cycles, samples the mux
// output in the last dwell cycle and publishes a 4-bit frame.
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   start       : begin a frame (level, sampled in IDLE)
//   stop        : abort scanning, highest priority
//   cont        : continuous mode, sampled at frame end
//   ch_en [3:0] : channel enable mask, latched at frame start
//   mux_out     : output of the downstream mux
//   sel   [1:0] : registered mux select
//   frame [3:0] : last completed frame (disabled channels read 0)
//   frame_valid : one-cycle pulse when frame is updated
//   busy        : high while scanning
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int DW_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              cont,
    input  logic [CH_NUM-1:0] ch_en,
    input  logic              mux_out,
    output logic [SEL_W-1:0]  sel,
    output logic [CH_NUM-1:0] frame,
    output logic              frame_valid,
    output logic              busy
);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CH_NUM-1:0]   frame_q, frame_d;
    logic                frame_valid_q, frame_valid_d;
    logic [DW_W-1:0]     cnt_q, cnt_d;
    logic [CH_NUM-1:0]   en_q, en_d;
    logic [CH_NUM-1:0]   part_q, part_d;

    logic [SEL_W-1:0]    first_sel;
    logic                first_last_unused;
    logic [SEL_W-1:0]    adv_sel;
    logic                adv_last;
    logic [CH_NUM-1:0]   part_sampled;
    logic                dwell_end;

    // Lowest enabled channel of the live mask, used when a frame begins.
    chan_next_sel u_first_sel (
        .en      (ch_en),
        .cur_sel (sel_q),
        .first   (1'b1),
        .nxt_sel (first_sel),
        .last    (first_last_unused)
    );

    // Next channel within the latched mask, used on channel advance.
    chan_next_sel u_adv_sel (
        .en      (en_q),
        .cur_sel (sel_q),
        .first   (1'b0),
        .nxt_sel (adv_sel),
        .last    (adv_last)
    );

    assign dwell_end = (cnt_q == DW_W'(DWELL - 1));

    always_comb begin
        part_sampled         = part_q;
        part_sampled[sel_q]  = mux_out;
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        cnt_d         = cnt_q;
        en_d          = en_q;
        part_d        = part_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop && (ch_en != '0)) begin
                    state_d = ST_SCAN;
                    en_d    = ch_en;
                    sel_d   = first_sel;
                    cnt_d   = '0;
                    part_d  = '0;
                end
            end
            ST_SCAN: begin
                if (stop) begin
                    // Abort wins even over a same-edge frame end.
                    state_d = ST_IDLE;
                end else if (dwell_end) begin
                    cnt_d = '0;
                    if (!adv_last) begin
                        sel_d  = adv_sel;
                        part_d = part_sampled;
                    end else begin
                        frame_d       = part_sampled & en_q;
                        frame_valid_d = 1'b1;
                        part_d        = '0;
                        if (cont && (ch_en != '0)) begin
                            // Back-to-back frame: no idle gap.
                            en_d  = ch_en;
                            sel_d = first_sel;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DW_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            cnt_q         <= '0;
            en_q          <= '0;
            part_q        <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            cnt_q         <= cnt_d;
            en_q          <= en_d;
            part_q        <= part_d;
        end
    end

    assign sel         = sel_q;
    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign busy        = (state_q == ST_SCAN);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances with DWELL = 4, 2 and 1, each
// fed by its own mux model (mux_out = pattern[sel]). Expected select,
// busy, valid and frame values come from closed-form cycle arithmetic over
// the list of enabled channels.
module tb_mux_scan_ctrl;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst_n_r   [NI];
    logic       start_r   [NI];
    logic       stop_r    [NI];
    logic       cont_r    [NI];
    logic [3:0] ch_en_r   [NI];
    logic [3:0] ipat_r    [NI];
    logic       mux_out_w [NI];
    logic [1:0] sel_w     [NI];
    logic [3:0] frame_w   [NI];
    logic       fv_w      [NI];
    logic       busy_w    [NI];

    logic [3:0] exp_frame [NI];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            assign mux_out_w[gi] = ipat_r[gi][sel_w[gi]];
            mux_scan_ctrl #(
                .DWELL((gi == 0) ? 4 : ((gi == 1) ? 2 : 1)),
                .DW_W (8)
            ) u_dut (
                .clk        (clk),
                .rst_n      (rst_n_r[gi]),
                .start      (start_r[gi]),
                .stop       (stop_r[gi]),
                .cont       (cont_r[gi]),
                .ch_en      (ch_en_r[gi]),
                .mux_out    (mux_out_w[gi]),
                .sel        (sel_w[gi]),
                .frame      (frame_w[gi]),
                .frame_valid(fv_w[gi]),
                .busy       (busy_w[gi])
            );
        end
    endgenerate

    function automatic int dwell_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
    endfunction

    function automatic int popcnt(input logic [3:0] m);
        int c = 0;
        for (int i = 0; i < 4; i++) if (m[i]) c++;
        return c;
    endfunction

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, k, $time, obs, exp);
        end
    endtask

    // One scan request; stop_cyc=0 means no abort.
    task automatic run_scan(input int k, input logic [3:0] mask, input logic [3:0] ip0,
                            input int nframes, input int stop_cyc, input bit hold_start);
        int d, n, p, tt, sel_exp;
        bit fv_exp;
        int lst[$];
        logic [3:0] ipf[$];
        d = dwell_of(k);
        for (int i = 0; i < 4; i++) if (mask[i]) lst.push_back(i);
        n  = lst.size();
        p  = n * d;
        tt = nframes * p;
        ipf.push_back(ip0);
        for (int f = 1; f < nframes; f++) ipf.push_back(4'($urandom));

        @(negedge clk);
        start_r[k] = 1'b1;
        ch_en_r[k] = mask;
        cont_r[k]  = (nframes > 1);
        stop_r[k]  = 1'b0;
        ipat_r[k]  = ip0;
        @(posedge clk);

        for (int t = 1; t <= tt + 1; t++) begin
            @(negedge clk);
            if (stop_cyc != 0 && t == stop_cyc + 1) begin
                chk("stop_busy", k, 8'(busy_w[k]), 8'd0);
                chk("stop_valid", k, 8'(fv_w[k]), 8'd0);
                chk("stop_frame", k, 8'(frame_w[k]), 8'(exp_frame[k]));
                start_r[k] = 1'b0;
                stop_r[k]  = 1'b0;
                break;
            end
            sel_exp = (t <= tt) ? lst[((t - 1) / d) % n] : lst[n - 1];
            fv_exp  = (t > 1) && ((t - 1) % p == 0);
            if (fv_exp) exp_frame[k] = ipf[(t - 1) / p - 1] & mask;
            chk("sel", k, 8'(sel_w[k]), 8'(sel_exp));
            chk("busy", k, 8'(busy_w[k]), 8'((t <= tt) ? 1 : 0));
            chk("valid", k, 8'(fv_w[k]), 8'(fv_exp));
            chk("frame", k, 8'(frame_w[k]), 8'(exp_frame[k]));
            if (t == tt + 1) begin
                start_r[k] = 1'b0;
                break;
            end
            start_r[k] = hold_start;
            if ((t - 1) % p == 0) ipat_r[k] = ipf[(t - 1) / p];
            if (t % p == 0) begin
                ch_en_r[k] = mask;
                cont_r[k]  = (t < tt);
            end else begin
                // Mid-frame noise on mask and cont must have no effect.
                ch_en_r[k] = 4'($urandom);
                cont_r[k]  = 1'($urandom);
            end
            stop_r[k] = (t == stop_cyc);
        end
        stop_r[k] = 1'b0;
        cont_r[k] = 1'b0;
    endtask

    task automatic idle_checks(input int k);
        @(negedge clk);
        start_r[k] = 1'b1; ch_en_r[k] = 4'b0000; stop_r[k] = 1'b0;
        @(negedge clk);
        chk("zero_mask_busy", k, 8'(busy_w[k]), 8'd0);
        chk("zero_mask_valid", k, 8'(fv_w[k]), 8'd0);
        start_r[k] = 1'b1; ch_en_r[k] = 4'b1111; stop_r[k] = 1'b1;
        @(negedge clk);
        chk("start_stop_busy", k, 8'(busy_w[k]), 8'd0);
        chk("start_stop_frame", k, 8'(frame_w[k]), 8'(exp_frame[k]));
        start_r[k] = 1'b0; stop_r[k] = 1'b0;
    endtask

    task automatic reset_mid(input int k);
        @(negedge clk);
        start_r[k] = 1'b1; ch_en_r[k] = 4'b1110; cont_r[k] = 1'b0;
        @(negedge clk);
        start_r[k] = 1'b0;
        chk("pre_rst_busy", k, 8'(busy_w[k]), 8'd1);
        repeat (2) @(negedge clk);
        rst_n_r[k] = 1'b0;
        @(negedge clk);
        exp_frame[k] = 4'b0000;
        chk("rst_sel", k, 8'(sel_w[k]), 8'd0);
        chk("rst_frame", k, 8'(frame_w[k]), 8'd0);
        chk("rst_busy", k, 8'(busy_w[k]), 8'd0);
        chk("rst_valid", k, 8'(fv_w[k]), 8'd0);
        start_r[k] = 1'b1; ch_en_r[k] = 4'b1111;
        @(negedge clk);
        chk("rst_hold_busy", k, 8'(busy_w[k]), 8'd0);
        chk("rst_hold_sel", k, 8'(sel_w[k]), 8'd0);
        start_r[k] = 1'b0;
        rst_n_r[k] = 1'b1;
    endtask

    initial begin
        int k, nf, sc, tt;
        logic [3:0] m;
        for (int i = 0; i < NI; i++) begin
            rst_n_r[i] = 1'b0; start_r[i] = 1'b0; stop_r[i] = 1'b0; cont_r[i] = 1'b0;
            ch_en_r[i] = 4'b0000; ipat_r[i] = 4'b0000; exp_frame[i] = 4'b0000;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset_sel", i, 8'(sel_w[i]), 8'd0);
            chk("reset_frame", i, 8'(frame_w[i]), 8'd0);
            chk("reset_valid", i, 8'(fv_w[i]), 8'd0);
            chk("reset_busy", i, 8'(busy_w[i]), 8'd0);
            rst_n_r[i] = 1'b1;
        end

        // Directed steps.
        run_scan(0, 4'b1111, 4'b1010, 1, 0, 1'b0);   // basic frame, valid cycle 17
        run_scan(0, 4'b0101, 4'b1111, 1, 0, 1'b0);   // channel skipping, valid cycle 9
        run_scan(1, 4'b0011, 4'b0110, 3, 0, 1'b0);   // continuous, valid 5/9/13
        run_scan(0, 4'b1111, 4'b0011, 1, 6, 1'b0);   // abort in cycle 6
        run_scan(2, 4'b1000, 4'b1000, 1, 0, 1'b0);   // DWELL=1, sample high
        run_scan(2, 4'b1000, 4'b0111, 1, 0, 1'b0);   // DWELL=1, sample low
        run_scan(0, 4'b1011, 4'b1001, 1, 0, 1'b1);   // start held during scan
        run_scan(1, 4'b1001, 4'b1111, 2, 4, 1'b0);   // abort on a frame-end edge
        for (int i = 0; i < NI; i++) idle_checks(i);
        reset_mid(0);
        reset_mid(2);

        // Randomized scenarios.
        repeat (30) begin
            k = $urandom_range(0, NI - 1);
            do m = 4'($urandom); while (m == 4'b0000);
            nf = $urandom_range(1, 3);
            tt = nf * popcnt(m) * dwell_of(k);
            sc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, tt) : 0;
            run_scan(k, m, 4'($urandom), nf, sc, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequential controller sitting directly upstream of the 4:1 channel multiplexer, `mux_4x1`.
- Drives the mux select lines `sel[1:0]` round-robin over the enabled channels and holds each select for a programmable dwell time.
- Samples the mux output `mux_out` once per channel and assembles a 4-bit frame.
- Presents the frame downstream with a one-cycle valid pulse.

Parameters:
- `DWELL`, default 4: cycles `sel` is held per channel; legal range 1..255.
- `DW_W`, default 8: dwell counter width; must satisfy 2**`DW_W` > `DWELL`.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  synchronous reset, active-low; takes effect only on the rising edge of `clk`.
- `start`  input  1  level; begins a frame when sampled high in IDLE.
- `stop`  input  1  level; aborts scanning and returns to IDLE.
- `cont`  input  1  continuous mode; sampled at each frame end.
- `ch_en`  input  4  channel enable mask; captured at each frame start.
- `mux_out`  input  1  output of the downstream 4:1 mux.
- `sel`  output  2  mux select, registered.
- `frame`  output  4  last completed frame; bit k = sample of channel k, disabled channels read 0.
- `frame_valid`  output  1  one-cycle pulse; `frame` was updated in this cycle.
- `busy`  output  1  high while in SCAN.

Behaviour:
- Reset, with `rst_n`=0 at an edge:
  - state=IDLE; `sel`=0, `frame`=0, `frame_valid`=0, `busy`=0; dwell counter=0; enable-mask register=0.
  - Reset mid-frame discards the partial frame. No `frame_valid` is produced.
- FSM has 2 states, IDLE and SCAN.
- IDLE -> SCAN:
  - Taken when `start`=1, `stop`=0 and `ch_en`!=0.
  - At that edge: `ch_en` is latched into the enable-mask register, `sel` is set to the lowest enabled channel, the counter is set to 0 and `busy`=1.
  - `start` with `ch_en`=0 is ignored; the block stays in IDLE.
- SCAN, counting and sampling:
  - The counter increments each cycle.
  - On the edge where counter==`DWELL`-1, `mux_out` is captured into the partial-frame bit [`sel`] and the counter is cleared.
  - If a higher enabled channel exists, `sel` moves to the next higher enabled channel, skipping disabled ones.
  - Otherwise the frame ends at that edge (see Frame end).
- Frame end, at the same edge as the last sample:
  - `frame` <= completed partial frame, with disabled bits forced to 0; `frame_valid`=1 for exactly the following cycle.
  - If `cont`=1 and `ch_en`!=0: remain in SCAN, re-latch `ch_en`, set `sel` to the new lowest enabled channel and clear the partial frame, so there is no idle gap.
  - If `cont`=1 and `ch_en`=0: go to IDLE.
  - If `cont`=0: go to IDLE with `busy`=0; `sel` holds its last value.
- Latency:
  - With N enabled channels, `frame_valid` is high in cycle N*`DWELL`+1, counting the edge that accepts `start` as the end of cycle 0.
  - Each `sel` value is stable for exactly `DWELL` cycles.
  - `mux_out` is sampled in the last cycle of each dwell, which gives the mux `DWELL`-1 cycles of settling.
- `stop`:
  - Has priority over every other event, including a same-edge frame end: next state IDLE, `busy`=0, no `frame_valid`, `frame` unchanged.
  - In IDLE, `stop` and `start` both high means the block stays in IDLE.
- `start` while in SCAN is ignored. Changes to `ch_en` during SCAN do not affect the current frame.
- `DWELL`=1: `sel` changes every cycle, and every cycle in SCAN is a sample cycle.
- Wrap-around: channel 3 is followed by the lowest enabled channel of the next frame, and only in continuous mode.

Decomposition:
- Shared package `mux_scan_pkg` holds:
  - the state encoding constants ST_IDLE=1'b0 and ST_SCAN=1'b1;
  - the constant CH_NUM=4;
  - the constant SEL_W=2.
- One combinational sub-module, `chan_next_sel`:
  - inputs: enable mask [3:0], current `sel` [1:0], and a `first` flag;
  - outputs: next enabled channel [1:0] and `last` (no higher enabled channel).
  - With `first`=1 it returns the lowest enabled channel.
  - It is used both at frame start and on channel advance.

Test Plan:
- Basic frame: `DWELL`=4, `ch_en`=4'b1111, `mux_out` driven = `i`[`sel`] with `i`=4'b1010, `start` pulse, `cont`=0 -> `sel` sequence 0,1,2,3 with each value held 4 cycles; `frame_valid` in cycle 17 with `frame`=4'b1010; `busy` low from cycle 17.
- Channel skipping: `ch_en`=4'b0101, `i`=4'b1111 -> `sel` takes values 0 then 2 only; `frame`=4'b0101; `frame_valid` in cycle 9.
- Continuous mode: `cont`=1, `ch_en`=4'b0011, `DWELL`=2 -> `frame_valid` pulses in cycles 5, 9, 13; `sel` returns to 0 in each of those cycles; `busy` stays 1 throughout.
- Abort: `stop`=1 in cycle 6 of a 4-channel frame -> IDLE next cycle, `busy`=0, no `frame_valid`, `frame` keeps its previous value.
- Reset mid-frame: `rst_n`=0 for one edge during SCAN -> `sel`=0, `frame`=0, `busy`=0 after that edge; with `rst_n` held low, asserting `start` causes no change.
- Edge cases:
  - `start` with `ch_en`=0 -> stays IDLE;
  - `DWELL`=1 with `ch_en`=4'b1000 -> `frame_valid` in cycle 2 with `frame`=4'b1000 or 4'b0000, matching `i`[3];
  - `start` held high during SCAN -> frame timing unaffected.
